prog_loader: RTL and testbench
==============================

# prog_loader

Boot/load controller for the pipelined RISC core. It accepts a byte stream over a valid/ready handshake and sequences it into the core's byte-wide instruction-memory write port, one address per byte. It holds the core in reset while loading, then waits a fixed flush interval before releasing it. It sits between the chip-level I/O and the core's `inst_address` / `inst_data` / instruction-write-enable / reset inputs.

## Interface
Parameters:
- `ADDR_W`, 7: instruction-memory byte address width; capacity is 2^ADDR_W bytes.
- `FLUSH_CYCLES`, 4: cycles the core stays held after the last write. Legal range is 1..15.

Ports:
- `clk` in 1: the single clock.
- `clr` in 1: reset, synchronous, active-high.
- `start` in 1: single-cycle pulse that opens a load session. Honoured in IDLE and RUN only.
- `abort` in 1: cancels a session. Honoured in LOAD and FLUSH.
- `load_len` in ADDR_W: byte count minus 1, so 0 means 1 byte and 127 means 128 bytes. Latched on an accepted `start`.
- `byte_valid` in 1: source has a byte on `byte_data`.
- `byte_data` in 8: payload byte.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `inst_address` out ADDR_W: registered write address.
- `inst_data` out 8: registered write data.
- `inst_we` out 1: registered write strobe, one cycle per byte.
- `core_hold` out 1: active-high reset to the core. Inverted externally to drive the core's `rst_n`.
- `busy` out 1: high in LOAD or FLUSH.
- `done` out 1: high in RUN.
- `checksum` out 8: mod-256 sum of all bytes accepted in the current or last session.

## Operation
- States: IDLE, LOAD, FLUSH, RUN. Encoding is free. The state is not visible externally except through `busy`, `done` and `core_hold`.
- Reset (`clr`=1 at a clock edge) puts the block in IDLE with:
  - `core_hold`=1
  - `inst_we`=0, `inst_address`=0, `inst_data`=0
  - `byte_ready`=0, `busy`=0, `done`=0, `checksum`=0
  - internal address counter = 0, flush counter = 0
- IDLE:
  - `byte_ready`=0, `core_hold`=1.
  - On `start`: latch `load_len`, clear the address counter and `checksum`, go to LOAD.
- LOAD:
  - `byte_ready`=1, decoded from state.
  - A transfer occurs when `byte_valid` and `byte_ready` are both high.
  - On each transfer:
    - `inst_address`<=counter, `inst_data`<=`byte_data`, `inst_we`<=1.
    - `checksum`<=`checksum`+`byte_data`, truncated to 8 bits.
    - counter<=counter+1.
  - If the counter equals the latched length, that transfer was the last byte: go to FLUSH and load the flush counter with `FLUSH_CYCLES`-1.
  - With no transfer, `inst_we`<=0 and the address/data registers hold their values.
  - `start` is ignored.
- FLUSH:
  - `byte_ready`=0, `core_hold`=1. The flush counter decrements each cycle.
  - When it reads 0, go to RUN.
  - `start` is ignored.
- RUN:
  - `core_hold`=0, `done`=1, `byte_ready`=0.
  - On `start`: same actions as from IDLE, go to LOAD. `core_hold` returns to 1 in the first LOAD cycle.
- `abort` in LOAD or FLUSH:
  - Go to IDLE. `core_hold` stays 1 and `checksum` keeps the partial sum.
  - A byte transferred in the abort cycle is still written.
- Simultaneous `start` and `abort` in RUN: `abort` is ignored and `start` is honoured.
- Address counter: ADDR_W+1 bits internally, so a full-capacity load (`load_len`=2^ADDR_W-1) terminates cleanly with no wrap onto address 0.
- `inst_we` is never high in any cycle other than the cycle immediately after a transfer.

## Timing
- Write latency: a byte transferred at edge N appears on `inst_we`/`inst_address`/`inst_data` during cycle N+1 (registered outputs).
- Throughput: one byte per cycle. Back-to-back `byte_valid` yields consecutive `inst_we` pulses at consecutive addresses.
- `byte_ready` is valid in the same cycle as state, with no combinational path from `byte_valid`.
- Last-byte timing, with the last byte accepted at edge N:
  - `byte_ready`=0 from cycle N+1.
  - FLUSH occupies cycles N+1 .. N+`FLUSH_CYCLES`.
  - RUN, `core_hold`=0 and `done`=1 begin at cycle N+1+`FLUSH_CYCLES`.
- `start` accepted at edge S: `busy`=1 and `byte_ready`=1 in cycle S+1. When restarting from RUN, `core_hold`=1 and `done`=0 in cycle S+1.
- `clr` mid-session: next cycle shows full reset values. Memory contents already written stay as they are; the block does not clear them.

## Test plan
- Reset: hold `clr` 2 cycles with random inputs → `core_hold`=1, `inst_we`=0, `byte_ready`=0, `done`=0, `checksum`=0.
- Streaming load, `load_len`=3, bytes 0x13,0x00,0xA5,0xFF back-to-back:
  - `inst_we` pulses at addresses 0..3 with matching data, one cycle after each transfer.
  - `checksum`=0xB7.
  - `done` rises exactly `FLUSH_CYCLES`+1 cycles after the last transfer.
- Throttled source, `load_len`=1, `byte_valid` toggling 1,0,0,1 → exactly 2 `inst_we` pulses (addresses 0 then 1), no write during the idle gaps.
- Full capacity, `load_len`=127, 128 bytes of value i → last write is address 127, no write to address 0 after the first, state enters FLUSH.
- Abort:
  - `abort` asserted after 2 of 5 bytes → IDLE next cycle, `core_hold` stays 1, `done` never rises, `checksum` equals the sum of the first 2 bytes.
  - `abort` asserted in RUN has no effect.
- Reload from RUN: `start` with `load_len`=0 and byte 0x42 → `core_hold` is 1 in the next cycle, one write of 0x42 to address 0, `checksum`=0x42, RUN reached again. `clr` pulsed mid-LOAD returns the block to the reset state.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: streams bytes into the core's instruction memory while holding
// the core in reset, then waits a fixed flush interval before releasing it.
module prog_loader #(
    parameter int ADDR_W       = 7,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] inst_address,
    output logic [7:0]        inst_data,
    output logic              inst_we,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_RUN
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t            state_reg, state_next;
    // One extra bit so a full-capacity load never wraps back onto address 0.
    logic [ADDR_W:0]   addr_cnt_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [3:0]        flush_cnt_reg;

    logic xfer;
    logic last_byte;
    logic start_ok;

    assign byte_ready = (state_reg == S_LOAD);
    assign busy       = (state_reg == S_LOAD) || (state_reg == S_FLUSH);
    assign done       = (state_reg == S_RUN);
    assign core_hold  = (state_reg != S_RUN);

    assign xfer      = byte_valid && byte_ready;
    assign last_byte = (addr_cnt_reg == {1'b0, len_reg});
    assign start_ok  = start && ((state_reg == S_IDLE) || (state_reg == S_RUN));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD: begin
                if (abort)                  state_next = S_IDLE;
                else if (xfer && last_byte) state_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (abort)                    state_next = S_IDLE;
                else if (flush_cnt_reg == '0) state_next = S_RUN;
            end
            S_RUN:   if (start) state_next = S_LOAD;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg     <= S_IDLE;
            addr_cnt_reg  <= '0;
            len_reg       <= '0;
            flush_cnt_reg <= '0;
            inst_we       <= 1'b0;
            inst_address  <= '0;
            inst_data     <= '0;
            checksum      <= '0;
        end else begin
            state_reg <= state_next;
            inst_we   <= xfer;
            if (start_ok) begin
                len_reg      <= load_len;
                addr_cnt_reg <= '0;
                checksum     <= '0;
            end
            // A byte accepted in an abort cycle is still committed.
            if (xfer) begin
                inst_address <= addr_cnt_reg[ADDR_W-1:0];
                inst_data    <= byte_data;
                checksum     <= checksum + byte_data;
                addr_cnt_reg <= addr_cnt_reg + 1'b1;
            end
            if (xfer && last_byte)
                flush_cnt_reg <= FLUSH_INIT;
            else if ((state_reg == S_FLUSH) && (flush_cnt_reg != '0))
                flush_cnt_reg <= flush_cnt_reg - 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed table-driven bench for prog_loader plus a full-capacity load sequence.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       clr, start, abort, byte_valid;
    logic [6:0] load_len;
    logic [7:0] byte_data;
    logic       byte_ready, inst_we, core_hold, busy, done;
    logic [6:0] inst_address;
    logic [7:0] inst_data, checksum;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(7), .FLUSH_CYCLES(4)) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .inst_address(inst_address), .inst_data(inst_data), .inst_we(inst_we),
        .core_hold(core_hold), .busy(busy), .done(done), .checksum(checksum)
    );

    // Inputs applied before an edge, outputs expected just after it.
    typedef struct {
        logic       clr, start, abort;
        logic [6:0] len;
        logic       valid;
        logic [7:0] din;
        logic       ready, we;
        logic [6:0] addr;
        logic [7:0] data;
        logic       hold, busy, done;
        logic [7:0] cs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, s, a, input logic [6:0] l, input logic v,
                       input logic [7:0] d, input logic rdy, we, input logic [6:0] ad,
                       input logic [7:0] da, input logic h, b, dn, input logic [7:0] cs);
        vec_t t;
        t.clr = c; t.start = s; t.abort = a; t.len = l; t.valid = v; t.din = d;
        t.ready = rdy; t.we = we; t.addr = ad; t.data = da;
        t.hold = h; t.busy = b; t.done = dn; t.cs = cs;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic c, s, a, input logic [6:0] l, input logic v,
                         input logic [7:0] d);
        @(negedge clk);
        clr = c; start = s; abort = a; load_len = l; byte_valid = v; byte_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; abort = 1'b0; load_len = '0;
        byte_valid = 1'b0; byte_data = '0;

        //   clr s a len v din   rdy we addr data  h b d cs
        // reset with noisy inputs
        add(1, 1, 0, 7'd5, 1, 8'h55, 0, 0, 7'd0, 8'h00, 1, 0, 0, 8'h00);
        add(1, 0, 1, 7'd9, 1, 8'hAA, 0, 0, 7'd0, 8'h00, 1, 0, 0, 8'h00);
        // streaming load of 4 bytes
        add(0, 1, 0, 7'd3, 0, 8'h00, 1, 0, 7'd0, 8'h00, 1, 1, 0, 8'h00);
        add(0, 0, 0, 7'd0, 1, 8'h13, 1, 1, 7'd0, 8'h13, 1, 1, 0, 8'h13);
        add(0, 0, 0, 7'd0, 1, 8'h00, 1, 1, 7'd1, 8'h00, 1, 1, 0, 8'h13);
        add(0, 0, 0, 7'd0, 1, 8'hA5, 1, 1, 7'd2, 8'hA5, 1, 1, 0, 8'hB8);
        add(0, 0, 0, 7'd0, 1, 8'hFF, 0, 1, 7'd3, 8'hFF, 1, 1, 0, 8'hB7);
        add(0, 1, 0, 7'd0, 1, 8'h77, 0, 0, 7'd3, 8'hFF, 1, 1, 0, 8'hB7);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd3, 8'hFF, 1, 1, 0, 8'hB7);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd3, 8'hFF, 1, 1, 0, 8'hB7);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd3, 8'hFF, 0, 0, 1, 8'hB7);
        // abort in RUN ignored
        add(0, 0, 1, 7'd0, 0, 8'h00, 0, 0, 7'd3, 8'hFF, 0, 0, 1, 8'hB7);
        // reload from RUN with start+abort together, one byte 0x42
        add(0, 1, 1, 7'd0, 0, 8'h00, 1, 0, 7'd3, 8'hFF, 1, 1, 0, 8'h00);
        add(0, 0, 0, 7'd0, 1, 8'h42, 0, 1, 7'd0, 8'h42, 1, 1, 0, 8'h42);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd0, 8'h42, 1, 1, 0, 8'h42);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd0, 8'h42, 1, 1, 0, 8'h42);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd0, 8'h42, 1, 1, 0, 8'h42);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd0, 8'h42, 0, 0, 1, 8'h42);
        // throttled source, 2 bytes with idle gaps
        add(0, 1, 0, 7'd1, 0, 8'h00, 1, 0, 7'd0, 8'h42, 1, 1, 0, 8'h00);
        add(0, 0, 0, 7'd0, 1, 8'h11, 1, 1, 7'd0, 8'h11, 1, 1, 0, 8'h11);
        add(0, 0, 0, 7'd0, 0, 8'hEE, 1, 0, 7'd0, 8'h11, 1, 1, 0, 8'h11);
        add(0, 0, 0, 7'd0, 0, 8'hEE, 1, 0, 7'd0, 8'h11, 1, 1, 0, 8'h11);
        add(0, 0, 0, 7'd0, 1, 8'h22, 0, 1, 7'd1, 8'h22, 1, 1, 0, 8'h33);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd1, 8'h22, 1, 1, 0, 8'h33);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd1, 8'h22, 1, 1, 0, 8'h33);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd1, 8'h22, 1, 1, 0, 8'h33);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd1, 8'h22, 0, 0, 1, 8'h33);
        // abort after 2 of 5 bytes
        add(0, 1, 0, 7'd4, 0, 8'h00, 1, 0, 7'd1, 8'h22, 1, 1, 0, 8'h00);
        add(0, 0, 0, 7'd0, 1, 8'h10, 1, 1, 7'd0, 8'h10, 1, 1, 0, 8'h10);
        add(0, 0, 0, 7'd0, 1, 8'h20, 1, 1, 7'd1, 8'h20, 1, 1, 0, 8'h30);
        add(0, 0, 1, 7'd0, 0, 8'h00, 0, 0, 7'd1, 8'h20, 1, 0, 0, 8'h30);
        add(0, 0, 0, 7'd0, 1, 8'h99, 0, 0, 7'd1, 8'h20, 1, 0, 0, 8'h30);
        // clr mid-load
        add(0, 1, 0, 7'd5, 0, 8'h00, 1, 0, 7'd1, 8'h20, 1, 1, 0, 8'h00);
        add(0, 0, 0, 7'd0, 1, 8'h05, 1, 1, 7'd0, 8'h05, 1, 1, 0, 8'h05);
        add(1, 0, 0, 7'd0, 1, 8'h06, 0, 0, 7'd0, 8'h00, 1, 0, 0, 8'h00);
        // abort in FLUSH
        add(0, 1, 0, 7'd0, 0, 8'h00, 1, 0, 7'd0, 8'h00, 1, 1, 0, 8'h00);
        add(0, 0, 0, 7'd0, 1, 8'h01, 0, 1, 7'd0, 8'h01, 1, 1, 0, 8'h01);
        add(0, 0, 1, 7'd0, 0, 8'h00, 0, 0, 7'd0, 8'h01, 1, 0, 0, 8'h01);
        add(0, 0, 0, 7'd0, 0, 8'h00, 0, 0, 7'd0, 8'h01, 1, 0, 0, 8'h01);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].start, vecs[i].abort, vecs[i].len,
                  vecs[i].valid, vecs[i].din);
            chk("byte_ready", i, 32'(byte_ready), 32'(vecs[i].ready));
            chk("inst_we", i, 32'(inst_we), 32'(vecs[i].we));
            chk("inst_address", i, 32'(inst_address), 32'(vecs[i].addr));
            chk("inst_data", i, 32'(inst_data), 32'(vecs[i].data));
            chk("core_hold", i, 32'(core_hold), 32'(vecs[i].hold));
            chk("busy", i, 32'(busy), 32'(vecs[i].busy));
            chk("done", i, 32'(done), 32'(vecs[i].done));
            chk("checksum", i, 32'(checksum), 32'(vecs[i].cs));
            $display("[TB] step %0d we=%0b addr=%0d data=%02h hold=%0b busy=%0b done=%0b cs=%02h",
                     i, inst_we, inst_address, inst_data, core_hold, busy, done, checksum);
        end

        // Full-capacity load: 128 bytes of value i, sum = 0xC0.
        drive(0, 1, 0, 7'd127, 0, 8'h00);
        chk("full_start_busy", 0, 32'(busy), 32'd1);
        for (int i = 0; i < 128; i++) begin
            drive(0, 0, 0, 7'd0, 1, 8'(i));
            chk("full_we", i, 32'(inst_we), 32'd1);
            chk("full_addr", i, 32'(inst_address), 32'(i));
            chk("full_data", i, 32'(inst_data), 32'(i));
        end
        $display("[TB] full load last write addr=%0d data=%02h", inst_address, inst_data);
        chk("full_flush_ready", 0, 32'(byte_ready), 32'd0);
        chk("full_flush_busy", 0, 32'(busy), 32'd1);
        chk("full_checksum", 0, 32'(checksum), 32'hC0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 7'd0, 1, 8'h00);
            chk("full_flush_we", k, 32'(inst_we), 32'd0);
            chk("full_flush_done", k, 32'(done), 32'd0);
        end
        drive(0, 0, 0, 7'd0, 0, 8'h00);
        chk("full_run_done", 0, 32'(done), 32'd1);
        chk("full_run_hold", 0, 32'(core_hold), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
